dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory responder that services the load/store requests driven by the core's MEM stage.
- Accepts one request per cycle as byte-lane masks, an address, right-justified write data and a sign-extend flag.
- Returns a registered, lane-shifted and optionally sign-extended read word one cycle later.
- Also hosts two memory-mapped words: a free-running cycle timer and a sticky "tohost" halt register used by simulation to end a test.

Parameters:
DMEM_BASE  32'h0000_0000  byte address of RAM word 0
DMEM_WORDS  4096  RAM depth in 32-bit words (power of 2)
TIMER_ADDR  32'h1000_0000  read-only cycle counter address
TOHOST_ADDR  32'h1000_0004  halt register address (write-only)

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
addr  in  32  byte address of the request
rden  in  4  read size mask: 0001 byte, 0011 half, 1111 word, 0000 no read
rden_SEXT  in  1  sign-extend read result (byte/half only)
wren  in  4  write size mask, same encoding as rden
wrdata  in  32  right-justified store data
rd_vld  out  1  read response valid
rddata  out  32  read response data
err  out  1  request fault pulse, aligned with the response cycle
err_code  out  2  0 none, 1 misaligned, 2 unmapped, 3 illegal mask or rd+wr collision
halt  out  1  sticky, set by first valid tohost write
halt_code  out  32  data of that write

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset:
  - rd_vld=0, rddata=0, err=0, err_code=0, halt=0, halt_code=0, timer=0.
  - RAM contents are not reset.
  - A request presented in a cycle with rst=1 is discarded, including any write.
- Request: valid when rden!=0 or wren!=0.
- Legal masks are 0001, 0011 and 1111. Any other nonzero mask, or rden and wren both nonzero, gives fault 3.
- Alignment:
  - Half access with addr[0]=1 gives fault 1.
  - Word access with addr[1:0]!=0 gives fault 1.
- Mapping:
  - RAM index = (addr-DMEM_BASE)>>2; the address is mapped when 0 <= index < DMEM_WORDS.
  - TIMER_ADDR and TOHOST_ADDR are mapped.
  - Everything else gives fault 2.
- Fault priority: 3 > 1 > 2.
- Faulted requests:
  - No state is modified.
  - err=1 and err_code are set in the next cycle.
  - A faulted read still returns rd_vld=1 with rddata=0 so the pipeline never stalls.
- Write (RAM):
  - Byte lane mask = wren << addr[1:0].
  - Data = wrdata << (8*addr[1:0]).
  - Committed at the clock edge ending the request cycle.
  - A read in the following cycle observes the new data.
- Read (RAM):
  - The word is fetched at the request edge, then shifted right by 8*addr[1:0] using the registered offset.
  - The result is masked to the access size, then sign-extended from bit 7 or bit 15 when rden_SEXT=1, else zero-extended.
  - Word reads ignore rden_SEXT.
- Read latency: exactly 1 cycle.
  - rd_vld and rddata are valid in the cycle after the request.
  - rd_vld is a single-cycle pulse per read.
  - Back-to-back reads are supported every cycle.
  - rddata holds its last value when rd_vld=0.
- Timer:
  - 32-bit counter, +1 every cycle after reset; wraps 0xFFFF_FFFF to 0.
  - Reads return the value sampled in the request cycle.
  - Byte/half reads select lanes like RAM.
  - Writes to the timer are silently ignored (no fault).
- tohost:
  - A word write when halt=0 sets halt=1 and halt_code=wrdata.
  - Later writes are ignored and halt stays sticky until rst.
  - A byte/half write to tohost gives fault 3.
  - A read of tohost returns 0 with no fault.
- err is a one-cycle pulse. err_code holds its value until the next request response; it is 0 after a clean response.

Test Plan:
- SW 0xDEADBEEF to 0x10, then LW 0x10 the next cycle -> rd_vld=1 one cycle later, rddata=0xDEADBEEF.
- After that store:
  - LB 0x13 with SEXT=1 -> 0xFFFFFFDE.
  - LBU 0x12 -> 0x000000AD.
  - LH 0x12 with SEXT=1 -> 0xFFFFDEAD.
  - SB 0x55 to 0x11, then LW 0x10 -> 0xDEAD55EF.
- LH 0x11 -> err=1, err_code=1, rd_vld=1, rddata=0. SW to 0x0000_4000 (DMEM_WORDS=4096) -> err_code=2, RAM unchanged.
- rden=1111 and wren=1111 together -> err_code=3, no write. A mask of 0101 -> err_code=3.
- Release rst, then LW TIMER_ADDR at cycle 10 after reset -> rddata=10. Force the timer to 0xFFFFFFFF -> it reads 0 on the next cycle.
- SW 0x1 to TOHOST_ADDR -> halt=1 and halt_code=1 next cycle. Then SW 0x2 -> halt_code stays 1. Then rst=1 for one cycle -> halt=0.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the core's MEM stage.
// Serves byte/half/word loads and stores into a word-organised RAM and hosts
// two memory-mapped words: a free-running cycle timer (read-only) and a
// sticky tohost halt register (write-only, first word write wins).
//
// Request/response protocol: there is no handshake back-pressure. A request
// is valid in any cycle where rden != 0 or wren != 0 and is always accepted.
// Every read, faulted or not, is answered by a single-cycle rd_vld pulse
// exactly one cycle later; err/err_code report the request's outcome in that
// same response cycle. Requests presented while rst=1 are dropped.
module dmem_responder #(
  parameter logic [31:0] DMEM_BASE   = 32'h0000_0000,
  parameter int          DMEM_WORDS  = 4096,
  parameter logic [31:0] TIMER_ADDR  = 32'h1000_0000,
  parameter logic [31:0] TOHOST_ADDR = 32'h1000_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [3:0]  rden,
  input  logic        rden_SEXT,
  input  logic [3:0]  wren,
  input  logic [31:0] wrdata,
  output logic        rd_vld,
  output logic [31:0] rddata,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        halt,
  output logic [31:0] halt_code
);

  localparam int          ADDR_BITS  = $clog2(DMEM_WORDS);
  localparam logic [32:0] DMEM_BYTES = 33'(DMEM_WORDS) << 2;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_ALIGN = 2'd1;
  localparam logic [1:0] ERR_UNMAP = 2'd2;
  localparam logic [1:0] ERR_ILLEG = 2'd3;

  logic [31:0] mem [DMEM_WORDS];

  logic [31:0] timer_q;
  logic        halt_q;
  logic [31:0] halt_code_q;

  // Registered read stage: raw word plus the info needed to align/extend it.
  logic        rd_vld_q;
  logic [31:0] rd_word_q;
  logic [1:0]  rd_off_q;
  logic [3:0]  rd_size_q;
  logic        rd_sext_q;
  logic        err_q;
  logic [1:0]  err_code_q;

  // Request decode
  logic                 is_rd;
  logic                 is_wr;
  logic                 is_req;
  logic [3:0]           mask;
  logic                 mask_ok;
  logic [31:0]          ram_off;
  logic                 ram_hit;
  logic [ADDR_BITS-1:0] ram_idx;
  logic                 timer_hit;
  logic                 tohost_hit;
  logic                 fault_illeg;
  logic                 fault_align;
  logic                 fault_unmap;
  logic                 fault;
  logic [1:0]           fault_code;
  logic                 do_ram_wr;
  logic                 do_halt_wr;
  logic [3:0]           wr_lanes;
  logic [31:0]          wr_data_sh;

  // Classify the incoming request and resolve its fault code (3 > 1 > 2).
  always_comb begin
    is_rd   = (rden != 4'b0000);
    is_wr   = (wren != 4'b0000);
    is_req  = is_rd | is_wr;
    mask    = is_rd ? rden : wren;
    mask_ok = (mask == MASK_B) || (mask == MASK_H) || (mask == MASK_W);

    // Out-of-range addresses below the base wrap to large offsets, so one
    // unsigned compare covers both bounds.
    ram_off    = addr - DMEM_BASE;
    ram_hit    = ({1'b0, ram_off} < DMEM_BYTES);
    ram_idx    = ram_off[ADDR_BITS+1:2];
    timer_hit  = (addr[31:2] == TIMER_ADDR[31:2]);
    tohost_hit = (addr[31:2] == TOHOST_ADDR[31:2]);

    fault_illeg = (is_rd && is_wr) || !mask_ok ||
                  (is_wr && tohost_hit && (wren != MASK_W));
    fault_align = ((mask == MASK_H) && addr[0]) ||
                  ((mask == MASK_W) && (addr[1:0] != 2'b00));
    fault_unmap = !(ram_hit || timer_hit || tohost_hit);

    fault      = is_req && (fault_illeg || fault_align || fault_unmap);
    fault_code = ERR_NONE;
    if (fault_illeg)      fault_code = ERR_ILLEG;
    else if (fault_align) fault_code = ERR_ALIGN;
    else if (fault_unmap) fault_code = ERR_UNMAP;

    do_ram_wr  = !rst && is_wr && !fault && ram_hit;
    do_halt_wr = !rst && is_wr && !fault && tohost_hit && !halt_q;
    wr_lanes   = wren << addr[1:0];
    wr_data_sh = wrdata << {addr[1:0], 3'b000};
  end

  // RAM byte-lane writes; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (do_ram_wr && wr_lanes[i]) begin
        mem[ram_idx][8*i +: 8] <= wr_data_sh[8*i +: 8];
      end
    end
  end

  // Free-running cycle counter, zero in the first cycle after reset.
  always_ff @(posedge clk) begin
    if (rst) timer_q <= 32'd0;
    else     timer_q <= timer_q + 32'd1;
  end

  // Sticky halt register: only the first clean word write is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      halt_q      <= 1'b0;
      halt_code_q <= 32'd0;
    end else if (do_halt_wr) begin
      halt_q      <= 1'b1;
      halt_code_q <= wrdata;
    end
  end

  // Response stage: capture the source word and fault status for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q   <= 1'b0;
      rd_word_q  <= 32'd0;
      rd_off_q   <= 2'd0;
      rd_size_q  <= MASK_W;
      rd_sext_q  <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      rd_vld_q <= is_rd;
      err_q    <= fault;
      if (is_req) err_code_q <= fault_code;
      // Read-side registers only move on reads so rddata holds otherwise.
      if (is_rd) begin
        rd_off_q  <= addr[1:0];
        rd_size_q <= rden;
        rd_sext_q <= rden_SEXT;
        if (fault)          rd_word_q <= 32'd0;
        else if (ram_hit)   rd_word_q <= mem[ram_idx];
        else if (timer_hit) rd_word_q <= timer_q;
        else                rd_word_q <= 32'd0;
      end
    end
  end

  // Align the registered word to bit 0 and zero/sign-extend to the size.
  logic [31:0] rd_shifted;
  always_comb begin
    rd_shifted = rd_word_q >> {rd_off_q, 3'b000};
    case (rd_size_q)
      MASK_B:  rddata = {{24{rd_sext_q & rd_shifted[7]}}, rd_shifted[7:0]};
      MASK_H:  rddata = {{16{rd_sext_q & rd_shifted[15]}}, rd_shifted[15:0]};
      default: rddata = rd_shifted;
    endcase
  end

  assign rd_vld    = rd_vld_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign halt      = halt_q;
  assign halt_code = halt_code_q;

endmodule
